// File: rtl/seq_tx.sv
// seq_tx: serial frame transmitter, sync pattern then MSB-first payload, one bit per clock.
// Optional trailing even-parity bit when SEQ_TX_PARITY_EN is defined.
module seq_tx #(
    parameter int                DATA_W = 8,
    parameter int                SYNC_W = 4,
    parameter logic [SYNC_W-1:0] SYNC   = 4'b1101
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [DATA_W-1:0] data,
    output logic              out,
    output logic              busy,
    output logic              done
);

    localparam int MAX_W = (SYNC_W > DATA_W) ? SYNC_W : DATA_W;
    localparam int CW    = $clog2(MAX_W) + 1;

    localparam logic [CW-1:0] SYNC_LAST = CW'(SYNC_W - 1);
    localparam logic [CW-1:0] DATA_LAST = CW'(DATA_W - 1);
    localparam logic [CW-1:0] DATA_PEN  = CW'((DATA_W >= 2) ? DATA_W - 2 : 0);

`ifdef SEQ_TX_PARITY_EN
    localparam bit PAR_EN = 1'b1;
`else
    localparam bit PAR_EN = 1'b0;
`endif

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SYNC,
        ST_DATA,
        ST_PAR
    } state_t;

    state_t            state;
    logic [CW-1:0]     cnt;
    logic [SYNC_W-1:0] sshift;
    logic [DATA_W-1:0] dshift;
`ifdef SEQ_TX_PARITY_EN
    logic              par;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= ST_IDLE;
            cnt    <= '0;
            sshift <= '0;
            dshift <= '0;
            out    <= 1'b0;
            busy   <= 1'b0;
            done   <= 1'b0;
`ifdef SEQ_TX_PARITY_EN
            par    <= 1'b0;
`endif
        end else begin
            case (state)
                ST_IDLE: begin
                    out  <= 1'b0;
                    busy <= 1'b0;
                    done <= 1'b0;
                    cnt  <= '0;
                    if (start) begin
                        // The first sync bit goes straight onto the registered line,
                        // so the shifter holds the pattern already advanced by one.
                        state  <= ST_SYNC;
                        sshift <= SYNC << 1;
                        dshift <= data;
                        out    <= SYNC[SYNC_W-1];
                        busy   <= 1'b1;
`ifdef SEQ_TX_PARITY_EN
                        par    <= ^data;
`endif
                    end
                end
                ST_SYNC: begin
                    if (cnt == SYNC_LAST) begin
                        state  <= ST_DATA;
                        cnt    <= '0;
                        out    <= dshift[DATA_W-1];
                        dshift <= dshift << 1;
                        done   <= !PAR_EN && (DATA_W == 1);
                    end else begin
                        cnt    <= cnt + 1'b1;
                        out    <= sshift[SYNC_W-1];
                        sshift <= sshift << 1;
                    end
                end
                ST_DATA: begin
                    if (cnt == DATA_LAST) begin
                        cnt <= '0;
`ifdef SEQ_TX_PARITY_EN
                        state <= ST_PAR;
                        out   <= par;
                        done  <= 1'b1;
`else
                        state <= ST_IDLE;
                        out   <= 1'b0;
                        busy  <= 1'b0;
                        done  <= 1'b0;
`endif
                    end else begin
                        cnt    <= cnt + 1'b1;
                        out    <= dshift[DATA_W-1];
                        dshift <= dshift << 1;
                        done   <= !PAR_EN && (cnt == DATA_PEN);
                    end
                end
`ifdef SEQ_TX_PARITY_EN
                ST_PAR: begin
                    state <= ST_IDLE;
                    cnt   <= '0;
                    out   <= 1'b0;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
`endif
                default: begin
                    state <= ST_IDLE;
                    cnt   <= '0;
                    out   <= 1'b0;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_tx.sv
// Directed bench for seq_tx: per-cycle {out,busy,done} expectations queued at stimulus time.
module tb_seq_tx;

    logic       clk;
    logic       rst;
    logic       start;
    logic [7:0] data;
    logic       out;
    logic       busy;
    logic       done;

    int tests = 0;
    int fails = 0;

    logic [2:0] exp_q[$];

    seq_tx dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .data  (data),
        .out   (out),
        .busy  (busy),
        .done  (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected line activity for one frame followed by n_idle idle cycles.
    task automatic push_frame(input logic [7:0] d, input int n_idle);
        logic [3:0] sync_pat;
        logic       last;
        sync_pat = 4'b1101;
        for (int i = 3; i >= 0; i--) exp_q.push_back({sync_pat[i], 1'b1, 1'b0});
        for (int i = 7; i >= 0; i--) begin
`ifdef SEQ_TX_PARITY_EN
            last = 1'b0;
`else
            last = (i == 0);
`endif
            exp_q.push_back({d[i], 1'b1, last});
        end
`ifdef SEQ_TX_PARITY_EN
        exp_q.push_back({^d, 1'b1, 1'b1});
`endif
        for (int i = 0; i < n_idle; i++) exp_q.push_back(3'b000);
    endtask

    task automatic check_now(input string tag, input logic [2:0] expv);
        logic [2:0] got;
        got = {out, busy, done};
        tests++;
        assert (got === expv) else begin
            fails++;
            $error("FAIL %s got {out,busy,done}=%b expected=%b", tag, got, expv);
        end
    endtask

    task automatic check_n(input string tag, input int n);
        logic [2:0] expv;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (exp_q.size() == 0) begin
                tests++;
                fails++;
                $error("FAIL %s scoreboard empty at cycle %0d got=%b expected=entry", tag, i, {out, busy, done});
            end else begin
                expv = exp_q.pop_front();
                check_now(tag, expv);
            end
        end
    endtask

    initial begin
        rst   = 1'b1;
        start = 1'b1;
        data  = 8'hA5;

        // Reset with start held high
        repeat (2) begin
            @(negedge clk);
            check_now("reset", 3'b000);
        end
        start = 1'b0;
        rst   = 1'b0;
        exp_q.push_back(3'b000);
        exp_q.push_back(3'b000);
        check_n("post_reset_idle", 2);

        // Basic frame A5
        start = 1'b1;
        data  = 8'hA5;
        push_frame(8'hA5, 2);
        @(posedge clk);
        #1 start = 1'b0;
        data = 8'h00;
        check_n("frame_a5", exp_q.size());

        // Streaming with start held high: one idle cycle between frames
        @(negedge clk);
        start = 1'b1;
        data  = 8'h00;
        push_frame(8'h00, 1);
        push_frame(8'h00, 1);
        push_frame(8'h00, 0);
        check_n("stream_00", exp_q.size());
        start = 1'b0;
        exp_q.push_back(3'b000);
        exp_q.push_back(3'b000);
        check_n("stream_end", 2);

        // Start and data changes while busy are ignored
        start = 1'b1;
        data  = 8'hFF;
        push_frame(8'hFF, 3);
        @(posedge clk);
        #1 start = 1'b0;
        check_n("busy_ign_a", 3);
        start = 1'b1;
        data  = 8'h00;
        check_n("busy_ign_b", 5);
        start = 1'b0;
        check_n("busy_ign_c", exp_q.size());

        // Mid-frame asynchronous reset during the 3rd data bit
        start = 1'b1;
        data  = 8'hE7;
        push_frame(8'hE7, 0);
        @(posedge clk);
        #1 start = 1'b0;
        check_n("abort_pre", 6);
        @(posedge clk);
        #2 rst = 1'b1;
        #1 check_now("abort_async", 3'b000);
        exp_q.delete();
        @(negedge clk);
        check_now("abort_held", 3'b000);
        rst = 1'b0;
        for (int i = 0; i < 8; i++) exp_q.push_back(3'b000);
        check_n("abort_no_done", 8);

        // Fresh frame after abort
        start = 1'b1;
        data  = 8'h3C;
        push_frame(8'h3C, 2);
        @(posedge clk);
        #1 start = 1'b0;
        check_n("after_abort_3c", exp_q.size());

        // Odd-parity payload then even-parity payload
        start = 1'b1;
        data  = 8'h07;
        push_frame(8'h07, 1);
        @(posedge clk);
        #1 start = 1'b0;
        check_n("frame_07", exp_q.size());
        start = 1'b1;
        data  = 8'h03;
        push_frame(8'h03, 2);
        @(posedge clk);
        #1 start = 1'b0;
        check_n("frame_03", exp_q.size());

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/seq_tx.md
# seq_tx

Serial frame transmitter that emits the 4-bit sync pattern 1101 followed by a parallel-loaded payload on a one-bit line, one bit per clock. It drives the serial input of the 1101 sequence-detector family, for example in self-checking loopback benches and link bring-up. A start/busy/done handshake with the parallel side lets frames be issued back-to-back.

## Interface
- DATA_W, 8: payload width in bits, at least 1.
- SYNC, 4'b1101: sync pattern, transmitted MSB first.
- SYNC_W, 4: sync pattern width in bits, at least 1.

- clk  input  1  clock; all state changes on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  frame request; sampled on rising edges only while busy=0.
- data  input  DATA_W  payload; captured on the edge that accepts start.
- out  output  1  serial line, registered; idle level 0.
- busy  output  1  registered; high while a frame is on the line.
- done  output  1  registered; one-cycle pulse coincident with the last bit of a frame.

## Operation
- States:
  - IDLE: out=0, busy=0.
  - SYNC: SYNC_W cycles.
  - DATA: DATA_W cycles.
  - PAR: 1 cycle, present only with SEQ_TX_PARITY_EN.
- IDLE transitions:
  - start=1 at an edge: latch data into the shift register, load SYNC into the sync shifter, clear the bit counter, go to SYNC.
  - start=0: stay in IDLE.
- SYNC: out = current sync MSB, shifting left each cycle. After SYNC_W bits, go to DATA.
- DATA: out = payload MSB first, shifting left each cycle. After DATA_W bits, go to PAR if enabled, else IDLE.
- PAR: out = even parity of the latched payload (XOR of all DATA_W bits). Then go to IDLE.
- Bit counter:
  - Width is clog2(max(SYNC_W, DATA_W)) + 1.
  - It counts 0..N-1 within each state and is cleared on every state change.
  - It never wraps past N-1.
- done is high exactly in the final bit cycle of the frame: the last data bit, or the parity bit when enabled.
- busy is high in every cycle where out carries a frame bit.
- start while busy=1 is ignored, and data changes while busy=1 have no effect. No queuing.
- Reset mid-frame:
  - The frame is aborted immediately.
  - out=0, busy=0, done=0; no done pulse for the aborted frame.
  - State returns to IDLE and the shift registers and counter are cleared.
- Payload bits may themselves contain 1101. Framing-level ambiguity is the receiver's concern; this block does not stuff bits.

## Timing
- Reset values: out=0, busy=0, done=0, state IDLE, counter 0, shift registers 0.
- Latency: start accepted at edge k → first sync bit on out and busy=1 in the cycle following edge k.
- Frame length L = SYNC_W + DATA_W, plus 1 with parity: 12 by default, 13 with parity.
- busy stays high for exactly L cycles. The edge ending the last bit returns to IDLE with out=0.
- Back-to-back:
  - If start is high on that return edge, it is not accepted, because busy was still 1 when sampled.
  - It is accepted on the following edge.
  - Minimum inter-frame gap is therefore exactly 1 idle cycle with out=0.
- If start and rst are both high, rst wins.

## Configuration
- SEQ_TX_PARITY_EN defined: the PAR state is compiled in, L = SYNC_W + DATA_W + 1, and done moves to the parity bit.
- SEQ_TX_PARITY_EN undefined: PAR logic is absent, L = SYNC_W + DATA_W, and done is on the last data bit.

## Test plan
- Reset: assert rst for 2 cycles → out=0, busy=0, done=0. Hold start=1 during reset → no frame starts until after release.
- Basic frame: start pulse with data=8'hA5 → out sequence 1,1,0,1,1,0,1,0,0,1,0,1. busy high for 12 cycles. done high only in cycle 12. Then out=0.
- Streaming: start held at 1, data=8'h00 → repeated frames 1101_00000000, each separated by exactly one out=0 idle cycle.
- Ignore while busy: start pulse with data=8'hFF, then start=1 and data=8'h00 during the frame → frame still carries FF, and no extra frame is queued from that request.
- Mid-frame reset: pulse rst asynchronously during the 3rd data bit → out, busy, done go to 0 without waiting for a clock, and no done pulse occurs. The next start with data=8'h3C produces a complete 12-bit frame.
- Parity (SEQ_TX_PARITY_EN defined): data=8'h07 → 13-bit frame ending in parity bit 1. data=8'h03 → parity bit 0. done is on bit 13.
